cache_mem_arbiter: RTL and testbench

//  Shares the single physical-memory Wishbone port between the instruction-cache and

---
 rtl/cache_mem_arbiter.sv | 74 +++++++
 tb/tb_cache_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin arbiter sharing one Wishbone memory port between icache and dcache
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_ack,
    output logic              i_rty,
    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_rty,
    output logic [LINE_W-1:0] rdata,
    output logic              mem_cyc,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              mem_rty
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    state_t state;
    logic last_gnt;
    logic req_i, req_d, gi, gd;
    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;
    assign gi = state == GNT_I;
    assign gd = state == GNT_D;
    assign rdata = mem_rdata;
    // Grant in IDLE (tie goes to the port that did not win last); release on ack, retry or abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b0;
        end else begin
            case (state)
                IDLE:    state <= (req_i & req_d) ? (last_gnt ? GNT_I : GNT_D) :
                                  req_i ? GNT_I : req_d ? GNT_D : IDLE;
                GNT_I:   if (mem_ack | mem_rty | ~req_i) begin
                             state    <= IDLE;
                             last_gnt <= 1'b0;
                         end
                GNT_D:   if (mem_ack | mem_rty | ~req_d) begin
                             state    <= IDLE;
                             last_gnt <= 1'b1;
                         end
                default: state <= IDLE;
            endcase
        end
    end
    // Route the granted port to memory and completion back to it; ack overrides retry
    always_comb begin
        mem_cyc   = (gi & i_cyc) | (gd & d_cyc);
        mem_stb   = (gi & i_stb) | (gd & d_stb);
        mem_we    = (gi & i_we)  | (gd & d_we);
        mem_addr  = gi ? i_addr  : gd ? d_addr  : '0;
        mem_wdata = gi ? i_wdata : gd ? d_wdata : '0;
        i_ack     = gi & mem_ack;
        d_ack     = gd & mem_ack;
        i_rty     = gi & mem_rty & ~mem_ack;
        d_rty     = gd & mem_rty & ~mem_ack;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: vector table, hand sequence and randomized model check of the memory arbiter
module tb_cache_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst;
    logic i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [LW-1:0] i_wdata, d_wdata, rdata, mem_wdata, mem_rdata;
    logic i_ack, i_rty, d_ack, d_rty;
    logic mem_cyc, mem_stb, mem_we, mem_ack, mem_rty;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ack(i_ack), .i_rty(i_rty),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rty(d_rty),
        .rdata(rdata),
        .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_rty(mem_rty)
    );

    typedef struct {
        logic rst, ic, dc, dw, ack, rty;
        logic e_cyc, e_we;
        logic [AW-1:0] e_addr;
        logic e_iack, e_irty, e_dack, e_drty;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic r, ic, dc, dw, ack, rty, ec, ew,
                                input logic [AW-1:0] ea, input logic [3:0] e_resp);
        vec_t v;
        v.rst = r; v.ic = ic; v.dc = dc; v.dw = dw; v.ack = ack; v.rty = rty;
        v.e_cyc = ec; v.e_we = ew; v.e_addr = ea;
        {v.e_iack, v.e_irty, v.e_dack, v.e_drty} = e_resp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc = 0; i_stb = 0; i_we = 0; i_addr = 32'h2000; i_wdata = {8{32'h1234_5678}};
        d_cyc = 0; d_stb = 0; d_we = 0; d_addr = 32'h1000; d_wdata = {32{8'hA5}};
        mem_ack = 0; mem_rty = 0; mem_rdata = '0;
    endtask

    // abstract reference: who holds the memory port (0 none, 1 icache, 2 dcache) and who won last
    int owner, prev;

    task automatic model_check_and_step();
        logic [LW+AW+2:0] exp_mem;
        logic [3:0] exp_resp;
        logic ri, rd;
        ri = i_cyc & i_stb;
        rd = d_cyc & d_stb;
        exp_mem = (owner == 1) ? {i_cyc, i_stb, i_we, i_addr, i_wdata} :
                  (owner == 2) ? {d_cyc, d_stb, d_we, d_addr, d_wdata} : '0;
        exp_resp = '0;
        if (owner == 1) exp_resp = {mem_ack, mem_rty & !mem_ack, 2'b00};
        if (owner == 2) exp_resp = {2'b00, mem_ack, mem_rty & !mem_ack};
        chk("rand_mem", {mem_cyc, mem_stb, mem_we, mem_addr, mem_wdata}, exp_mem);
        chk("rand_resp", {i_ack, i_rty, d_ack, d_rty}, exp_resp);
        chk("rand_rdata", rdata, mem_rdata);
        if (rst) begin
            owner = 0; prev = 1;
        end else if (owner == 0) begin
            if (ri && rd) owner = (prev == 1) ? 2 : 1;
            else if (ri) owner = 1;
            else if (rd) owner = 2;
        end else if (mem_ack || mem_rty || (owner == 1 ? !ri : !rd)) begin
            prev = owner;
            owner = 0;
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        // rows: rst ic dc dw ack rty | cyc we addr | {iack irty dack drty}
        tbl[0]  = mk(0,0,1,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[1]  = mk(0,0,1,0,0,0, 1,0,32'h1000, 4'b0000);
        tbl[2]  = mk(0,0,1,0,0,0, 1,0,32'h1000, 4'b0000);
        tbl[3]  = mk(0,0,1,0,1,0, 1,0,32'h1000, 4'b0010);
        tbl[4]  = mk(0,0,0,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[5]  = mk(1,0,0,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[6]  = mk(0,1,1,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[7]  = mk(0,1,1,0,0,0, 1,0,32'h1000, 4'b0000);
        tbl[8]  = mk(0,1,1,0,1,0, 1,0,32'h1000, 4'b0010);
        tbl[9]  = mk(0,1,0,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[10] = mk(0,1,0,0,0,0, 1,0,32'h2000, 4'b0000);
        tbl[11] = mk(0,1,0,0,1,0, 1,0,32'h2000, 4'b1000);
        tbl[12] = mk(0,1,1,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[13] = mk(0,1,1,0,0,0, 1,0,32'h1000, 4'b0000);
        tbl[14] = mk(0,1,1,0,1,0, 1,0,32'h1000, 4'b0010);
        tbl[15] = mk(0,1,1,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[16] = mk(0,1,1,0,0,1, 1,0,32'h2000, 4'b0100);
        tbl[17] = mk(0,1,1,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[18] = mk(0,1,1,0,1,1, 1,0,32'h1000, 4'b0010);
        tbl[19] = mk(0,0,0,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[20] = mk(0,0,1,1,0,0, 0,0,32'h0,    4'b0000);
        tbl[21] = mk(0,0,1,1,0,0, 1,1,32'h1000, 4'b0000);
        tbl[22] = mk(0,0,0,0,0,0, 0,0,32'h1000, 4'b0000);
        tbl[23] = mk(0,0,0,0,1,0, 0,0,32'h0,    4'b0000);
        tbl[24] = mk(0,0,0,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[25] = mk(0,1,0,0,0,0, 0,0,32'h0,    4'b0000);
        tbl[26] = mk(0,1,0,0,0,0, 1,0,32'h2000, 4'b0000);
        tbl[27] = mk(1,1,0,0,0,0, 1,0,32'h2000, 4'b0000);
        tbl[28] = mk(0,0,0,0,1,0, 0,0,32'h0,    4'b0000);
        tbl[29] = mk(0,0,0,0,0,0, 0,0,32'h0,    4'b0000);

        next_cycle();
        next_cycle();
        rst = 0;
        @(negedge clk);
        chk("reset_mem", {mem_cyc, mem_stb, mem_we, mem_addr, mem_wdata}, '0);
        chk("reset_resp", {i_ack, i_rty, d_ack, d_rty}, '0);
        next_cycle();

        for (int n = 0; n < 30; n++) begin
            rst = tbl[n].rst;
            i_cyc = tbl[n].ic; i_stb = tbl[n].ic;
            d_cyc = tbl[n].dc; d_stb = tbl[n].dc; d_we = tbl[n].dw;
            mem_ack = tbl[n].ack; mem_rty = tbl[n].rty;
            @(negedge clk);
            chk($sformatf("row%0d_mem", n), {mem_cyc, mem_stb, mem_we, mem_addr},
                {tbl[n].e_cyc, tbl[n].e_cyc, tbl[n].e_we, tbl[n].e_addr});
            chk($sformatf("row%0d_resp", n), {i_ack, i_rty, d_ack, d_rty},
                {tbl[n].e_iack, tbl[n].e_irty, tbl[n].e_dack, tbl[n].e_drty});
            next_cycle();
        end

        // dcache write-back wins the tie while the icache fill waits
        idle_inputs();
        rst = 0;
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1; d_we = 1;
        @(negedge clk);
        chk("wb_idle_we", {mem_we, mem_wdata}, '0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wb_wdata", {mem_we, mem_wdata, i_ack}, {1'b1, {32{8'hA5}}, 1'b0});
            next_cycle();
        end
        mem_ack = 1;
        @(negedge clk);
        chk("wb_ack", {d_ack, i_ack, mem_we}, 3'b101);
        next_cycle();
        mem_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0;
        @(negedge clk);
        chk("wb_gap", {mem_we, mem_wdata, i_ack}, '0);
        next_cycle();
        @(negedge clk);
        chk("fill_wdata", {mem_cyc, mem_we, mem_addr, mem_wdata, i_ack},
            {1'b1, 1'b0, 32'h2000, {8{32'h1234_5678}}, 1'b0});
        next_cycle();
        mem_ack = 1; mem_rdata = {8{32'hCAFE_F00D}};
        @(negedge clk);
        chk("fill_ack", {i_ack, d_ack, rdata}, {2'b10, {8{32'hCAFE_F00D}}});
        next_cycle();

        // randomized traffic against the reference model
        idle_inputs();
        rst = 1;
        next_cycle();
        owner = 0; prev = 1;
        rst = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) i_cyc = $urandom_range(1);
            if ($urandom_range(3) == 0) i_stb = ($urandom_range(4) != 0);
            if ($urandom_range(3) == 0) d_cyc = $urandom_range(1);
            if ($urandom_range(3) == 0) d_stb = ($urandom_range(4) != 0);
            i_we = $urandom_range(1); d_we = $urandom_range(1);
            i_addr = $urandom; d_addr = $urandom;
            i_wdata = rand_line(); d_wdata = rand_line(); mem_rdata = rand_line();
            mem_ack = ($urandom_range(3) == 0);
            mem_rty = ($urandom_range(7) == 0);
            rst = ($urandom_range(63) == 0);
            @(negedge clk);
            model_check_and_step();
            next_cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
